// File: rtl/draw_pkg.sv
// Shared types and constants for the glyph-string draw path.
// Screen geometry, glyph codes and the sequencer state encoding.
package draw_pkg;

    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int TYPE_W     = 5;
    localparam int MAX_GLYPHS = 16;

    localparam logic [TYPE_W-1:0] G_BLANK = 5'd0;
    localparam logic [TYPE_W-1:0] G_B     = 5'd16;
    localparam logic [TYPE_W-1:0] G_E     = 5'd17;
    localparam logic [TYPE_W-1:0] G_G     = 5'd19;
    localparam logic [TYPE_W-1:0] G_I     = 5'd20;
    localparam logic [TYPE_W-1:0] G_N     = 5'd22;
    localparam logic [TYPE_W-1:0] G_O     = 5'd23;
    localparam logic [TYPE_W-1:0] G_R     = 5'd25;
    localparam logic [TYPE_W-1:0] G_T     = 5'd26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_DRAW,
        ST_DONE,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/draw_text_sequencer.sv
// Walks a glyph table and issues one draw request per non-blank glyph.
// Applies a screen offset, supports run-time length and abort.
module draw_text_sequencer
    import draw_pkg::*;
#(
    parameter int                MAX_GLYPHS = draw_pkg::MAX_GLYPHS,
    parameter logic [TYPE_W-1:0] BLANK_TYPE = G_BLANK,
    parameter int                IDX_W      = $clog2(MAX_GLYPHS),
    parameter int                CNT_W      = $clog2(MAX_GLYPHS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_glyphs,
    input  logic [X_W-1:0]    x_off,
    input  logic [Y_W-1:0]    y_off,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [TYPE_W-1:0] tbl_type,
    input  logic [X_W-1:0]    tbl_x,
    input  logic [Y_W-1:0]    tbl_y,
    input  logic              draw_object_done,
    output logic              start_draw,
    output logic [TYPE_W-1:0] obj_type,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  glyph_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GLYPHS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [X_W-1:0]    xoff_q;
    logic [Y_W-1:0]    yoff_q;
    logic [TYPE_W-1:0] type_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;

    logic accept;
    logic last;
    logic blank;
    logic [CNT_W-1:0] len_clamped;

    assign accept      = (state_q == ST_IDLE) && start && !abort;
    assign last        = ((idx_q + ONE) == len_q);
    assign blank       = (tbl_type == BLANK_TYPE);
    assign len_clamped = (num_glyphs > MAX_CNT) ? MAX_CNT : num_glyphs;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; abort wins over a same-cycle draw completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = (num_glyphs == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                state_d = abort ? ST_RELEASE : ST_LOAD;
            end
            ST_LOAD: begin
                if (abort)
                    state_d = ST_RELEASE;
                else if (blank)
                    state_d = last ? ST_DONE : ST_FETCH;
                else
                    state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (abort)
                    state_d = ST_RELEASE;
                else if (draw_object_done)
                    state_d = last ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                if (!start)
                    state_d = ST_IDLE;
            end
            ST_RELEASE: begin
                if (!start)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: run parameters, glyph index, registered glyph, draw count
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            xoff_q <= '0;
            yoff_q <= '0;
            type_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        len_q  <= len_clamped;
                        xoff_q <= x_off;
                        yoff_q <= y_off;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (!abort) begin
                        type_q <= tbl_type;
                        x_q    <= tbl_x + xoff_q;
                        y_q    <= tbl_y + yoff_q;
                        if (blank)
                            idx_q <= idx_q + ONE;
                    end
                end
                ST_DRAW: begin
                    if (!abort && draw_object_done) begin
                        cnt_q <= cnt_q + ONE;
                        idx_q <= idx_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; glyph fields are gated so they read 0 outside DRAW
    always_comb begin
        tbl_idx     = idx_q[IDX_W-1:0];
        start_draw  = (state_q == ST_DRAW);
        obj_type    = start_draw ? type_q : '0;
        x_out       = start_draw ? x_q : '0;
        y_out       = start_draw ? y_q : '0;
        busy        = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                      (state_q == ST_DRAW);
        done        = (state_q == ST_DONE);
        glyph_count = cnt_q;
    end

endmodule

// File: tb/tb_draw_text_sequencer.sv
// Scoreboard bench for draw_text_sequencer.
// Models the glyph ROM and a fixed-latency draw engine.
module tb_draw_text_sequencer;
    import draw_pkg::*;

    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    typedef struct {
        logic [TYPE_W-1:0] t;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_glyphs;
    logic [X_W-1:0]    x_off;
    logic [Y_W-1:0]    y_off;
    logic [IDX_W-1:0]  tbl_idx;
    logic [TYPE_W-1:0] tbl_type;
    logic [X_W-1:0]    tbl_x;
    logic [Y_W-1:0]    tbl_y;
    logic              draw_object_done;
    logic              start_draw;
    logic [TYPE_W-1:0] obj_type;
    logic [X_W-1:0]    x_out;
    logic [Y_W-1:0]    y_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  glyph_count;

    logic [TYPE_W-1:0] t_type [16];
    logic [X_W-1:0]    t_x    [16];
    logic [Y_W-1:0]    t_y    [16];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   eng_cnt;
    logic prev_sd;

    draw_text_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .num_glyphs       (num_glyphs),
        .x_off            (x_off),
        .y_off            (y_off),
        .tbl_idx          (tbl_idx),
        .tbl_type         (tbl_type),
        .tbl_x            (tbl_x),
        .tbl_y            (tbl_y),
        .draw_object_done (draw_object_done),
        .start_draw       (start_draw),
        .obj_type         (obj_type),
        .x_out            (x_out),
        .y_out            (y_out),
        .busy             (busy),
        .done             (done),
        .glyph_count      (glyph_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Synchronous glyph ROM
    always @(posedge clk) begin
        tbl_type <= t_type[tbl_idx];
        tbl_x    <= t_x[tbl_idx];
        tbl_y    <= t_y[tbl_idx];
    end

    // Draw engine: done pulse after 5 clks of held request
    always @(posedge clk) begin
        if (reset || !start_draw || draw_object_done) begin
            draw_object_done <= 1'b0;
            eng_cnt          <= 0;
        end else if (eng_cnt == 4) begin
            draw_object_done <= 1'b1;
        end else begin
            eng_cnt <= eng_cnt + 1;
        end
    end

    // Each new request is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (start_draw && !prev_sd) begin
            if (sb.size() == 0) begin
                chk("unexp_draw", 32'(start_draw), 0);
            end else begin
                chk("obj_type", 32'(obj_type), 32'(sb[0].t));
                chk("x_out", 32'(x_out), 32'(sb[0].x));
                chk("y_out", 32'(y_out), 32'(sb[0].y));
                void'(sb.pop_front());
            end
        end
        prev_sd <= start_draw;
    end

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) begin
            t_type[i] = G_BLANK;
            t_x[i]    = '0;
            t_y[i]    = '0;
        end
    endtask

    task automatic set_g(input int i, input logic [TYPE_W-1:0] t,
                         input int x, input int y);
        t_type[i] = t;
        t_x[i]    = X_W'(x);
        t_y[i]    = Y_W'(y);
    endtask

    task automatic load_title();
        clear_tbl();
        set_g(0,  G_E, 110, 76);
        set_g(1,  G_N, 118, 76);
        set_g(2,  G_T, 126, 76);
        set_g(3,  G_E, 134, 76);
        set_g(4,  G_R, 142, 76);
        set_g(5,  G_T, 150, 76);
        set_g(6,  G_O, 158, 76);
        set_g(7,  G_B, 126, 121);
        set_g(8,  G_E, 134, 121);
        set_g(9,  G_G, 142, 121);
        set_g(10, G_I, 150, 121);
        set_g(11, G_N, 158, 121);
    endtask

    task automatic push_exp(input int n, input int xo, input int yo);
        exp_t e;
        int   lim;
        lim = (n > 16) ? 16 : n;
        for (int i = 0; i < lim; i++) begin
            if (t_type[i] != G_BLANK) begin
                e.t = t_type[i];
                e.x = X_W'((int'(t_x[i]) + xo) % 512);
                e.y = Y_W'((int'(t_y[i]) + yo) % 256);
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_run(input int n, input int xo, input int yo);
        @(negedge clk);
        num_glyphs = CNT_W'(n);
        x_off      = X_W'(xo);
        y_off      = Y_W'(yo);
        start      = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done)
            chk("done_timeout", 32'(done), 1);
    endtask

    task automatic wait_sd(input int budget, output int lat);
        lat = 0;
        while (lat < budget) begin
            @(negedge clk);
            lat++;
            if (start_draw)
                break;
        end
    endtask

    task automatic end_run();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", 32'(done), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_glyphs = '0;
        x_off      = '0;
        y_off      = '0;
        prev_sd    = 1'b0;
        clear_tbl();
        repeat (3) @(negedge clk);
        chk("rst_sd", 32'(start_draw), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(glyph_count), 0);
        chk("rst_type", 32'(obj_type), 0);
        chk("rst_idx", 32'(tbl_idx), 0);
        reset = 1'b0;

        // Full title string, latency and done hold
        load_title();
        push_exp(12, 0, 0);
        start_run(12, 0, 0);
        wait_sd(20, lat);
        chk("first_lat", 32'(lat), 3);
        wait_done(400);
        chk("title_cnt", 32'(glyph_count), 12);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(done), 1);
        chk("title_sb", 32'(sb.size()), 0);
        end_run();

        // Blank glyph skipped
        clear_tbl();
        set_g(0, G_E, 110, 76);
        set_g(1, G_BLANK, 118, 76);
        set_g(2, G_N, 126, 76);
        push_exp(3, 0, 0);
        start_run(3, 0, 0);
        wait_done(200);
        chk("blank_cnt", 32'(glyph_count), 2);
        chk("blank_sb", 32'(sb.size()), 0);
        end_run();

        // Offsets with x wrap
        clear_tbl();
        set_g(0, G_E, 110, 76);
        set_g(1, G_O, 500, 50);
        push_exp(2, 20, 10);
        start_run(2, 20, 10);
        wait_done(200);
        chk("off_cnt", 32'(glyph_count), 2);
        end_run();

        // Length clamp
        load_title();
        push_exp(20, 0, 0);
        start_run(20, 0, 0);
        wait_done(600);
        chk("clamp_cnt", 32'(glyph_count), 12);
        end_run();

        // Zero-length string
        start_run(0, 0, 0);
        @(negedge clk);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_cnt", 32'(glyph_count), 0);
        end_run();

        // Abort together with draw completion
        load_title();
        push_exp(1, 0, 0);
        start_run(12, 0, 0);
        lat = 0;
        while (!draw_object_done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_dod", 32'(draw_object_done), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_sd", 32'(start_draw), 0);
        chk("abort_cnt", 32'(glyph_count), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_type", 32'(obj_type), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done), 0);
            chk("abort_norestart", 32'(busy), 0);
        end
        start = 1'b0;
        @(negedge clk);
        push_exp(12, 0, 0);
        start_run(12, 0, 0);
        wait_done(400);
        chk("rerun_cnt", 32'(glyph_count), 12);
        end_run();

        // Reset while drawing
        push_exp(1, 0, 0);
        start_run(12, 0, 0);
        wait_sd(20, lat);
        chk("rst_draw_sd", 32'(start_draw), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_sd", 32'(start_draw), 0);
        chk("rst2_busy", 32'(busy), 0);
        chk("rst2_done", 32'(done), 0);
        chk("rst2_cnt", 32'(glyph_count), 0);
        start = 1'b0;
        reset = 1'b0;
        push_exp(1, 0, 0);
        start_run(1, 0, 0);
        wait_sd(20, lat);
        chk("rst2_lat", 32'(lat), 3);
        wait_done(100);
        chk("rst2_run_cnt", 32'(glyph_count), 1);
        end_run();

        chk("sb_left", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_err);
        $finish;
    end

endmodule
